// File: rtl/draw_scheduler.sv
// Per-frame erase/update/draw sequencer and plot-port arbiter for the drawers.
// Optional DRAW_TIMEOUT_EN adds a per-grant watchdog (TIMEOUT cycles).
module draw_scheduler #(
    parameter int N_CLIENTS = 3,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 3
`ifdef DRAW_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 4095
`endif
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          frame_tick,
    input  logic [N_CLIENTS-1:0]          req,
    input  logic [N_CLIENTS-1:0]          done,
    input  logic [N_CLIENTS*X_W-1:0]      cl_x,
    input  logic [N_CLIENTS*Y_W-1:0]      cl_y,
    input  logic [N_CLIENTS*COLOUR_W-1:0] cl_colour,
    input  logic [N_CLIENTS-1:0]          cl_plot,
    output logic [N_CLIENTS-1:0]          grant,
    output logic                          erase,
    output logic                          update_pos,
    output logic [X_W-1:0]                vga_x,
    output logic [Y_W-1:0]                vga_y,
    output logic [COLOUR_W-1:0]           vga_colour,
    output logic                          vga_plot,
    output logic                          busy,
    output logic                          overrun,
    output logic                          timeout_err
);

    typedef enum logic [2:0] {
        IDLE, E_ARB, E_RUN, UPDATE, D_ARB, D_RUN
    } state_t;

    localparam logic [N_CLIENTS-1:0] ONE = {{(N_CLIENTS-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [N_CLIENTS-1:0] pending_q, pending_d;
    logic [N_CLIENTS-1:0] grant_q, grant_d;
    logic                 erase_q, erase_d;
    logic                 overrun_q, overrun_d;
    logic [N_CLIENTS-1:0] lowest;
    logic                 in_run;
    logic                 client_done;
    logic                 wd_hit;
    logic                 finish;

    logic [X_W-1:0]       vga_x_q, sel_x;
    logic [Y_W-1:0]       vga_y_q, sel_y;
    logic [COLOUR_W-1:0]  vga_colour_q, sel_c;
    logic                 vga_plot_q;

    assign lowest      = pending_q & (~pending_q + ONE);
    assign in_run      = (state_q == E_RUN) || (state_q == D_RUN);
    assign client_done = |(done & grant_q);
    assign finish      = in_run && (client_done || wd_hit);

`ifdef DRAW_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;

    assign wd_hit = in_run && (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        wd_d = wd_q;
        to_d = to_q;
        if (in_run) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = '0;
        end
        if (wd_hit && !client_done) begin
            to_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout_err = to_q;
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        erase_d   = erase_q;
        overrun_d = overrun_q | (frame_tick & (state_q != IDLE));
        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d   = E_ARB;
                    pending_d = req;
                    erase_d   = 1'b1;
                end
            end
            E_ARB, D_ARB: begin
                if (pending_q == '0) begin
                    state_d = (state_q == E_ARB) ? UPDATE : IDLE;
                end else begin
                    grant_d = lowest;
                    state_d = (state_q == E_ARB) ? E_RUN : D_RUN;
                end
            end
            E_RUN, D_RUN: begin
                if (finish) begin
                    pending_d = pending_q & ~grant_q;
                    grant_d   = '0;
                    state_d   = (state_q == E_RUN) ? E_ARB : D_ARB;
                end
            end
            UPDATE: begin
                erase_d   = 1'b0;
                pending_d = req;
                state_d   = D_ARB;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // grant is one-hot or zero, so the OR-style select never mixes clients
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (grant_q[i]) begin
                sel_x = cl_x[i*X_W +: X_W];
                sel_y = cl_y[i*Y_W +: Y_W];
                sel_c = cl_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            grant_q      <= '0;
            erase_q      <= 1'b0;
            overrun_q    <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            erase_q      <= erase_d;
            overrun_q    <= overrun_d;
            vga_x_q      <= sel_x;
            vga_y_q      <= sel_y;
            vga_colour_q <= erase_q ? '0 : sel_c;
            vga_plot_q   <= |(cl_plot & grant_q);
        end
    end

    assign grant      = grant_q;
    assign erase      = erase_q;
    assign update_pos = (state_q == UPDATE);
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed self-checking bench for draw_scheduler.
// Define DRAW_TIMEOUT_EN to also exercise the grant watchdog with TIMEOUT=16.
module tb_draw_scheduler;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            resetn;
    logic            frame_tick;
    logic [N-1:0]    req, done, cl_plot;
    logic [N*XW-1:0] cl_x;
    logic [N*YW-1:0] cl_y;
    logic [N*CW-1:0] cl_colour;
    logic [N-1:0]    grant;
    logic            erase, update_pos, vga_plot, busy, overrun, timeout_err;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [CW-1:0]   vga_colour;

    int checks = 0;
    int errors = 0;
    int bcnt   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) bcnt <= bcnt + (busy ? 1 : 0);

    draw_scheduler #(
        .N_CLIENTS(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)
`ifdef DRAW_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
        .req(req), .done(done),
        .cl_x(cl_x), .cl_y(cl_y), .cl_colour(cl_colour), .cl_plot(cl_plot),
        .grant(grant), .erase(erase), .update_pos(update_pos),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant == '0 && n < 20) begin
            step();
            n++;
        end
    endtask

    // Serve one grant: grant is held exactly `hold` cycles (hold >= 3).
    task automatic serve(input int idx, input logic exp_er, input int hold,
                         input bit bad_done);
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        int used;
        x = (idx == 1) ? 8'd100 : XW'(30 + idx * 7);
        y = (idx == 1) ? 7'd50  : YW'(10 + idx);
        c = (idx == 1) ? 3'b110 : ((idx == 0) ? 3'b011 : 3'b101);
        wait_grant();
        chk("grant", grant, 32'(1 << idx));
        chk("erase", erase, exp_er);
        cl_x[idx*XW +: XW]      = x;
        cl_y[idx*YW +: YW]      = y;
        cl_colour[idx*CW +: CW] = c;
        cl_plot[idx]            = 1'b1;
        step();
        used = 1;
        chk("vga_x", vga_x, x);
        chk("vga_y", vga_y, y);
        chk("vga_colour", vga_colour, exp_er ? 3'b000 : c);
        chk("vga_plot", vga_plot, 1);
        if (bad_done) begin
            done = 3'b001;
            step();
            done = '0;
            used++;
            chk("grant_after_foreign_done", grant, 32'(1 << idx));
        end
        repeat (hold - 1 - used) step();
        done[idx] = 1'b1;
        step();
        done    = '0;
        cl_plot = '0;
        chk("grant_drop", grant, 0);
    endtask

    task automatic wait_upd();
        int n = 0;
        while (!update_pos && n < 20) begin
            step();
            n++;
        end
        chk("update_pos", update_pos, 1);
        step();
        chk("update_pos_1cyc", update_pos, 0);
        chk("erase_cleared", erase, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("idle", busy, 0);
    endtask

    initial begin
        int b0;
        resetn     = 1'b0;
        frame_tick = 1'b0;
        req        = '0;
        done       = '0;
        cl_plot    = '0;
        cl_x       = '0;
        cl_y       = '0;
        cl_colour  = '0;
        step();
        step();
        chk("rst_grant", grant, 0);
        chk("rst_erase", erase, 0);
        chk("rst_update", update_pos, 0);
        chk("rst_plot", vga_plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_vga_x", vga_x, 0);
        resetn = 1'b1;
        step();

        // full frame, all three clients, 5-cycle grants
        req = 3'b111;
        b0  = bcnt;
        tick();
        chk("busy_rise", busy, 1);
        serve(0, 1'b1, 5, 1'b0);
        serve(1, 1'b1, 5, 1'b0);
        serve(2, 1'b1, 5, 1'b0);
        wait_upd();
        serve(0, 1'b0, 5, 1'b0);
        serve(1, 1'b0, 5, 1'b0);
        serve(2, 1'b0, 5, 1'b0);
        wait_idle();
        chk("frame_cycles", bcnt - b0, 39);
        chk("no_overrun", overrun, 0);

        // tick while busy sets overrun, frame continues
        req = 3'b001;
        tick();
        tick();
        chk("overrun", overrun, 1);
        serve(0, 1'b1, 4, 1'b0);
        wait_upd();
        serve(0, 1'b0, 4, 1'b0);
        wait_idle();

        // single requester, foreign done ignored
        req = 3'b010;
        tick();
        serve(1, 1'b1, 5, 1'b1);
        wait_upd();
        serve(1, 1'b0, 5, 1'b1);
        wait_idle();
        chk("overrun_sticky", overrun, 1);

        // no requesters: update_pos still pulses
        req = 3'b000;
        tick();
        wait_upd();
        chk("empty_grant", grant, 0);
        wait_idle();

        // reset in the middle of a draw grant
        req = 3'b100;
        tick();
        serve(2, 1'b1, 5, 1'b0);
        wait_upd();
        wait_grant();
        chk("d_grant", grant, 3'b100);
        cl_plot = 3'b100;
        resetn  = 1'b0;
        step();
        chk("rst_mid_grant", grant, 0);
        chk("rst_mid_plot", vga_plot, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_overrun", overrun, 0);
        chk("rst_mid_timeout", timeout_err, 0);
        resetn  = 1'b1;
        cl_plot = '0;
        step();

`ifdef DRAW_TIMEOUT_EN
        begin
            int n = 0;
            req = 3'b011;
            tick();
            wait_grant();
            chk("wd_grant0", grant, 3'b001);
            while (grant == 3'b001 && n < 40) begin
                step();
                n++;
            end
            chk("wd_cycles", n, 16);
            chk("wd_err", timeout_err, 1);
            wait_grant();
            chk("wd_next", grant, 3'b010);
            resetn = 1'b0;
            step();
            resetn = 1'b1;
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
